// File: rtl/icache_fill_ctrl_if.sv
// icache_fill_ctrl_if -- fetch-side and memory-side signals of the I-cache.
//   slave  : the cache (answers imem requests, issues iREN/iaddr reads)
//   master : the environment (fetch stage + memory arbiter)
// Fetch side : imemREN, imemaddr -> ihit, imemload
// Memory side: iREN, iaddr -> iload, iwait
// Control    : inval (drop every valid bit)
interface icache_fill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              ihit;
  logic [DATA_W-1:0] imemload;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;
  logic              inval;

  modport slave (
    input  imemREN, imemaddr, iload, iwait, inval,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iload, iwait, inval,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl -- direct-mapped I-cache, SETS lines of WPB words, with a
// two-state miss/fill sequencer.
//   CLK  : clock, rising edge
//   nRST : synchronous active-low reset
//   bus  : icache_fill_ctrl_if.slave (fetch request/response, memory read
//          port, whole-cache invalidate)
// Hits are combinational. A miss latches tag/idx and fetches the block one
// word at a time; the line becomes valid only after its last word lands.
module icache_fill_ctrl #(
  parameter int SETS   = 16,
  parameter int WPB    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  icache_fill_ctrl_if.slave   bus
);
  localparam int OFF_W = $clog2(WPB);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  // Word counter keeps one bit even for single-word blocks.
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]  req_tag, ltag;
  logic [IDX_W-1:0]  req_idx, lidx;
  logic [CNT_W-1:0]  req_off, cnt;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] rd_word;
  logic              hit_raw, last_beat, miss_start, fill_we;
  logic              addr_unused;

  logic [SETS-1:0]                       line_valid, line_clr, line_we, line_done;
  logic [SETS-1:0][TAG_W-1:0]            line_tag;
  logic [SETS-1:0][WPB-1:0][DATA_W-1:0]  line_data;

  assign req_tag     = bus.imemaddr[ADDR_W-1 -: TAG_W];
  assign req_idx     = bus.imemaddr[OFF_W+2 +: IDX_W];
  assign addr_unused = ^bus.imemaddr[1:0];

  generate
    if (OFF_W > 0) begin : g_off
      assign req_off   = bus.imemaddr[2 +: OFF_W];
      assign fill_addr = {ltag, lidx, cnt, 2'b00};
    end else begin : g_nooff
      assign req_off   = '0;
      assign fill_addr = {ltag, lidx, 2'b00};
    end
  endgenerate

  assign hit_raw   = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  assign last_beat = (cnt == CNT_W'(WPB - 1));

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < WPB; w++)
      if (req_off == CNT_W'(w)) rd_word = line_data[req_idx][w];
  end
  assign bus.imemload = rd_word;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; inval wins over everything, including the last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.imemREN && !hit_raw && !bus.inval) state_nxt = FILL;
      FILL: if (bus.inval || (!bus.iwait && last_beat)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.ihit   = 1'b0;
    bus.iREN   = 1'b0;
    bus.iaddr  = '0;
    miss_start = 1'b0;
    fill_we    = 1'b0;
    case (state)
      IDLE: begin
        bus.ihit   = bus.imemREN && hit_raw && !bus.inval;
        miss_start = bus.imemREN && !hit_raw && !bus.inval;
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = fill_addr;
        // A beat landing together with inval is thrown away.
        fill_we   = !bus.iwait && !bus.inval;
      end
      default: ;
    endcase
  end

  // Miss address latch and beat counter
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ltag <= '0;
      lidx <= '0;
      cnt  <= '0;
    end else begin
      if (miss_start) begin
        ltag <= req_tag;
        lidx <= req_idx;
        cnt  <= '0;
      end
      if (state == FILL) begin
        if (bus.inval)       cnt <= '0;
        else if (!bus.iwait) cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // Per-line strobes: clear on miss entry, write per beat, commit on last beat.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      line_clr[s]  = miss_start && (req_idx == IDX_W'(s));
      line_we[s]   = fill_we && (lidx == IDX_W'(s));
      line_done[s] = fill_we && last_beat && (lidx == IDX_W'(s));
    end
  end

  generate
    for (genvar s = 0; s < SETS; s++) begin : g_line
      icache_line #(
        .TAG_W (TAG_W),
        .DATA_W(DATA_W),
        .WPB   (WPB),
        .CNT_W (CNT_W)
      ) u_line (
        .clk      (CLK),
        .rst_n    (nRST),
        .inval    (bus.inval),
        .clr      (line_clr[s]),
        .we       (line_we[s]),
        .fill_done(line_done[s]),
        .off      (cnt),
        .wdata    (bus.iload),
        .tag_in   (ltag),
        .valid    (line_valid[s]),
        .tag      (line_tag[s]),
        .data     (line_data[s])
      );
    end
  endgenerate
endmodule

// icache_line -- one cache line: valid bit, tag, WPB data words.
//   inval/clr drop the valid bit; we writes word 'off'; fill_done commits
//   tag and sets valid. Reset zeroes everything.
module icache_line #(
  parameter int TAG_W  = 25,
  parameter int DATA_W = 32,
  parameter int WPB    = 2,
  parameter int CNT_W  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        inval,
  input  logic                        clr,
  input  logic                        we,
  input  logic                        fill_done,
  input  logic [CNT_W-1:0]            off,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [TAG_W-1:0]            tag_in,
  output logic                        valid,
  output logic [TAG_W-1:0]            tag,
  output logic [WPB-1:0][DATA_W-1:0]  data
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (inval || clr)   valid <= 1'b0;
      else if (fill_done) valid <= 1'b1;
      if (fill_done) tag <= tag_in;
      for (int w = 0; w < WPB; w++)
        if (we && off == CNT_W'(w)) data[w] <= wdata;
    end
  end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: three instances (16x2, 8x4, 32x1) share a clock
// and reset. Every cycle all three are compared against a block-level model
// (which block number each line holds, and an in-flight fill described by
// block number and beats received). A vector table covers the main 16x2 flow.
module tb_icache_fill_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        ren[N], iwait[N], inval[N];
  logic [31:0] addr[N], iload[N];
  logic        o_ihit[N], o_iren[N];
  logic [31:0] o_load[N], o_iaddr[N];
  logic        cap_ihit[N], cap_iren[N];
  logic [31:0] cap_load[N], cap_iaddr[N];

  icache_fill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  icache_fill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  icache_fill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

`define HOOK(B, K) \
  assign B.imemREN  = ren[K]; \
  assign B.imemaddr = addr[K]; \
  assign B.iload    = iload[K]; \
  assign B.iwait    = iwait[K]; \
  assign B.inval    = inval[K]; \
  assign o_ihit[K]  = B.ihit; \
  assign o_load[K]  = B.imemload; \
  assign o_iren[K]  = B.iREN; \
  assign o_iaddr[K] = B.iaddr;

  `HOOK(bus0, 0)
  `HOOK(bus1, 1)
  `HOOK(bus2, 2)
`undef HOOK

  icache_fill_ctrl #(.SETS(16), .WPB(2), .ADDR_W(32), .DATA_W(32))
    dut0 (.CLK(clk), .nRST(nrst), .bus(bus0));
  icache_fill_ctrl #(.SETS(8),  .WPB(4), .ADDR_W(32), .DATA_W(32))
    dut1 (.CLK(clk), .nRST(nrst), .bus(bus1));
  icache_fill_ctrl #(.SETS(32), .WPB(1), .ADDR_W(32), .DATA_W(32))
    dut2 (.CLK(clk), .nRST(nrst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  // Reference model state
  int blk_in[N][32];   // block number held by each line, -1 when invalid
  bit fill_on[N];
  int fill_blk[N];
  int fill_beat[N];

  function automatic int sets_of(int k);
    return (k == 0) ? 16 : (k == 1) ? 8 : 32;
  endfunction

  function automatic int wpb_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 1;
  endfunction

  // Memory contents: 0x40 -> AAAA0000, 0x44 -> AAAA0004, high half tagged.
  function automatic logic [31:0] memword(logic [31:0] a);
    logic [31:0] v;
    v = 32'hAAAA0000 | ((a - 32'h40) & 32'h0000FFFF);
    if (a[31]) v = v ^ 32'h0F000000;
    return v;
  endfunction

  function automatic logic [31:0] fill_addr(int k);
    logic [31:0] w;
    w = 32'(fill_blk[k] * wpb_of(k) + fill_beat[k]);
    return w << 2;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 32; i++) blk_in[k][i] = -1;
      fill_on[k] = 1'b0;
    end
  endtask

  task automatic model_inval(int k);
    for (int i = 0; i < 32; i++) blk_in[k][i] = -1;
  endtask

  // Compare one DUT against the model, then advance the model over the edge.
  task automatic step_check(int j);
    int wa, blk, idx;
    bit e_hit;
    wa  = int'(addr[j][31:2]);
    blk = wa / wpb_of(j);
    idx = blk % sets_of(j);
    cap_ihit[j]  = o_ihit[j];
    cap_iren[j]  = o_iren[j];
    cap_load[j]  = o_load[j];
    cap_iaddr[j] = o_iaddr[j];
    if (!fill_on[j]) begin
      e_hit = ren[j] && !inval[j] && (blk_in[j][idx] == blk);
      chk("ihit", j, 32'(o_ihit[j]), 32'(e_hit));
      chk("iREN_idle", j, 32'(o_iren[j]), 32'd0);
      if (e_hit) chk("imemload", j, o_load[j], memword({addr[j][31:2], 2'b00}));
      if (inval[j]) model_inval(j);
      else if (ren[j] && !e_hit) begin
        blk_in[j][idx] = -1;
        fill_on[j]   = 1'b1;
        fill_blk[j]  = blk;
        fill_beat[j] = 0;
      end
    end else begin
      chk("ihit_fill", j, 32'(o_ihit[j]), 32'd0);
      chk("iREN_fill", j, 32'(o_iren[j]), 32'd1);
      chk("iaddr", j, o_iaddr[j], fill_addr(j));
      if (inval[j]) begin
        model_inval(j);
        fill_on[j] = 1'b0;
      end else if (!iwait[j]) begin
        fill_beat[j]++;
        if (fill_beat[j] == wpb_of(j)) begin
          blk_in[j][fill_blk[j] % sets_of(j)] = fill_blk[j];
          fill_on[j] = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive DUT k with the given inputs, keep the others idle.
  task automatic cycle(int k, bit r, logic [31:0] a, bit w, bit inv);
    for (int j = 0; j < N; j++) begin
      ren[j]   = (j == k) ? r   : 1'b0;
      addr[j]  = (j == k) ? a   : 32'h0;
      iwait[j] = (j == k) ? w   : 1'b0;
      inval[j] = (j == k) ? inv : 1'b0;
      iload[j] = (fill_on[j] && !iwait[j]) ? memword(fill_addr(j)) : $urandom();
    end
    #3;
    for (int j = 0; j < N; j++) step_check(j);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int k);
    int n = 0;
    while (fill_on[k] && n < 100) begin
      cycle(k, 1'b0, 32'h0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (fill_on[k]) begin
      errors++;
      $display("FAIL drain_bound dut%0d: fill still open after %0d cycles", k, n);
    end
  endtask

  // Request a until it hits, with w wait cycles before each accepted beat.
  task automatic access(int k, logic [31:0] a, int w);
    int n = 0, wc = 0;
    cycle(k, 1'b1, a, 1'b0, 1'b0);
    while (fill_on[k] && n < 200) begin
      if (wc < w) begin
        cycle(k, 1'b1, a, 1'b1, 1'b0);
        wc++;
      end else begin
        cycle(k, 1'b1, a, 1'b0, 1'b0);
        wc = 0;
      end
      n++;
    end
    cycle(k, 1'b1, a, 1'b0, 1'b0);
    chk("access_hit", k, 32'(cap_ihit[k]), 32'd1);
  endtask

  typedef struct {
    bit          r;
    logic [31:0] a;
    bit          w;
    bit          inv;
    bit          e_hit;
    bit          e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_load;
  } vec_t;

  vec_t tbl[22];

  initial begin
    // r, addr, wait, inval | ihit, iREN, iaddr, imemload
    tbl[0]  = '{1, 32'h0,  0, 0, 0, 0, 32'h0,  32'h0};        // miss right after reset
    tbl[1]  = '{0, 32'h0,  0, 0, 0, 1, 32'h0,  32'h0};
    tbl[2]  = '{0, 32'h0,  0, 0, 0, 1, 32'h4,  32'h0};
    tbl[3]  = '{1, 32'h44, 0, 0, 0, 0, 32'h0,  32'h0};        // cold miss 0x44
    tbl[4]  = '{1, 32'h44, 1, 0, 0, 1, 32'h40, 32'h0};
    tbl[5]  = '{1, 32'h44, 1, 0, 0, 1, 32'h40, 32'h0};
    tbl[6]  = '{1, 32'h44, 0, 0, 0, 1, 32'h40, 32'h0};
    tbl[7]  = '{1, 32'h44, 1, 0, 0, 1, 32'h44, 32'h0};
    tbl[8]  = '{1, 32'h44, 1, 0, 0, 1, 32'h44, 32'h0};
    tbl[9]  = '{1, 32'h44, 0, 0, 0, 1, 32'h44, 32'h0};
    tbl[10] = '{1, 32'h44, 0, 0, 1, 0, 32'h0,  32'hAAAA0004}; // 7 cycles after request
    tbl[11] = '{1, 32'h40, 0, 0, 1, 0, 32'h0,  32'hAAAA0000};
    tbl[12] = '{1, 32'h0,  0, 0, 1, 0, 32'h0,  32'hAAAAFFC0};
    tbl[13] = '{1, 32'h4,  1, 1, 0, 0, 32'h0,  32'h0};        // inval masks hit
    tbl[14] = '{1, 32'h4,  0, 0, 0, 0, 32'h0,  32'h0};        // now a miss
    tbl[15] = '{0, 32'h0,  1, 0, 0, 1, 32'h0,  32'h0};
    tbl[16] = '{0, 32'h0,  0, 1, 0, 1, 32'h0,  32'h0};        // inval aborts fill
    tbl[17] = '{0, 32'h0,  0, 0, 0, 0, 32'h0,  32'h0};        // iREN drops
    tbl[18] = '{1, 32'h0,  0, 0, 0, 0, 32'h0,  32'h0};        // still invalid
    tbl[19] = '{0, 32'h0,  0, 0, 0, 1, 32'h0,  32'h0};
    tbl[20] = '{0, 32'h0,  0, 1, 0, 1, 32'h4,  32'h0};        // inval + last beat
    tbl[21] = '{1, 32'h4,  0, 0, 0, 0, 32'h0,  32'h0};        // line left invalid

    // Reset held two edges with a live request on dut0
    nrst = 1'b0;
    for (int j = 0; j < N; j++) begin
      ren[j] = (j == 0); addr[j] = 32'h0; iwait[j] = 1'b0;
      inval[j] = 1'b0; iload[j] = 32'h0;
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < N; j++) begin
        chk("rst_ihit", j, 32'(o_ihit[j]), 32'd0);
        chk("rst_iREN", j, 32'(o_iren[j]), 32'd0);
        chk("rst_iaddr", j, o_iaddr[j], 32'h0);
        chk("rst_imemload", j, o_load[j], 32'h0);
      end
    end
    nrst = 1'b1;
    model_reset();

    for (int i = 0; i < 22; i++) begin
      cycle(0, tbl[i].r, tbl[i].a, tbl[i].w, tbl[i].inv);
      chk($sformatf("tbl%0d_ihit", i), 0, 32'(cap_ihit[0]), 32'(tbl[i].e_hit));
      chk($sformatf("tbl%0d_iREN", i), 0, 32'(cap_iren[0]), 32'(tbl[i].e_iren));
      if (tbl[i].e_iren) chk($sformatf("tbl%0d_iaddr", i), 0, cap_iaddr[0], tbl[i].e_iaddr);
      if (tbl[i].e_hit)  chk($sformatf("tbl%0d_load", i), 0, cap_load[0], tbl[i].e_load);
    end
    drain(0);

    // Conflict eviction: 0x440 shares idx with 0x40
    access(0, 32'h40, 1);
    access(0, 32'h440, 0);
    access(0, 32'h444, 0);
    cycle(0, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("conflict_miss", 0, 32'(cap_ihit[0]), 32'd0);
    drain(0);

    // Address change mid-fill: beats stay on 0x80/0x84
    cycle(0, 1'b1, 32'h80, 1'b0, 1'b0);
    cycle(0, 1'b1, 32'h100, 1'b1, 1'b0);
    chk("midfill_a0", 0, cap_iaddr[0], 32'h80);
    cycle(0, 1'b1, 32'h100, 1'b0, 1'b0);
    cycle(0, 1'b1, 32'h100, 1'b0, 1'b0);
    chk("midfill_a1", 0, cap_iaddr[0], 32'h84);
    cycle(0, 1'b0, 32'h100, 1'b0, 1'b0);
    chk("midfill_idle", 0, 32'(cap_iren[0]), 32'd0);
    cycle(0, 1'b1, 32'h100, 1'b0, 1'b0);
    chk("midfill_newmiss", 0, 32'(cap_ihit[0]), 32'd0);
    drain(0);
    access(0, 32'h100, 0);

    // Invalidate after filling two lines
    access(0, 32'h4, 0);
    access(0, 32'hC0, 0);
    cycle(0, 1'b1, 32'hC0, 1'b0, 1'b1);
    chk("inval_nohit", 0, 32'(cap_ihit[0]), 32'd0);
    cycle(0, 1'b1, 32'h4, 1'b0, 1'b0);
    chk("inval_miss_a", 0, 32'(cap_ihit[0]), 32'd0);
    drain(0);
    cycle(0, 1'b1, 32'hC0, 1'b0, 1'b0);
    chk("inval_miss_b", 0, 32'(cap_ihit[0]), 32'd0);
    drain(0);

    // Reset in the middle of a fill
    cycle(0, 1'b1, 32'h200, 1'b0, 1'b0);
    cycle(0, 1'b0, 32'h0, 1'b1, 1'b0);
    nrst = 1'b0;
    for (int j = 0; j < N; j++) begin ren[j] = 1'b0; iwait[j] = 1'b0; end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    cycle(0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_midfill_iREN", 0, 32'(cap_iren[0]), 32'd0);
    cycle(0, 1'b1, 32'hC0, 1'b0, 1'b0);
    chk("rst_clears_valid", 0, 32'(cap_ihit[0]), 32'd0);
    drain(0);

    // 8 sets x 4 words
    access(1, 32'h40, 1);
    cycle(1, 1'b1, 32'h48, 1'b0, 1'b0);
    chk("w4_word2", 1, cap_load[1], 32'hAAAA0008);
    cycle(1, 1'b1, 32'h80000040, 1'b0, 1'b0);
    chk("w4_topbit_miss", 1, 32'(cap_ihit[1]), 32'd0);
    drain(1);
    cycle(1, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("w4_evicted", 1, 32'(cap_ihit[1]), 32'd0);
    drain(1);

    // 32 sets x 1 word
    cycle(2, 1'b1, 32'h7C, 1'b0, 1'b0);
    chk("w1_miss", 2, 32'(cap_ihit[2]), 32'd0);
    cycle(2, 1'b1, 32'h7C, 1'b1, 1'b0);
    chk("w1_iaddr", 2, cap_iaddr[2], 32'h7C);
    cycle(2, 1'b1, 32'h7C, 1'b0, 1'b0);
    cycle(2, 1'b1, 32'h7C, 1'b0, 1'b0);
    chk("w1_hit", 2, 32'(cap_ihit[2]), 32'd1);
    cycle(2, 1'b1, 32'h8000007C, 1'b0, 1'b0);
    chk("w1_topbit_miss", 2, 32'(cap_ihit[2]), 32'd0);
    drain(2);

    // Random traffic on each configuration
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 400; i++) begin
        logic [31:0] a;
        a = {($urandom_range(0, 7) == 0), 20'h0, 9'($urandom_range(0, 511)), 2'b00};
        cycle(k, $urandom_range(0, 3) != 0, a, $urandom_range(0, 2) == 0,
              $urandom_range(0, 40) == 0);
      end
      drain(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
